// File: rtl/int_div_radix.sv
// Multi-cycle restoring integer divider retiring bits_per_cycle quotient bits per clock.
// Signed RISC-V DIV/REM semantics are built only when INT_DIV_SIGNED_EN is defined.
module int_div_radix #(
  parameter int bitwidth       = 32,
  parameter int bits_per_cycle = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
`ifdef INT_DIV_SIGNED_EN
  input  logic                is_signed,
`endif
  input  logic [bitwidth-1:0] a,
  input  logic [bitwidth-1:0] b,
  output logic                busy,
  output logic                ack,
  output logic [bitwidth-1:0] quotient,
  output logic [bitwidth-1:0] remainder,
  output logic                div_by_zero
);

  localparam int W     = bitwidth;
  localparam int BPC   = bits_per_cycle;
  localparam int STEPS = W / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd, dvs, quo, rem;
  logic [W-1:0]  dvd_n, quo_n, rem_n;
  logic [W-1:0]  a_mag, b_mag, q_fix, r_fix;
  logic [W:0]    pr;
  logic          zero, accept, start;

  assign zero   = (b == '0);
  assign accept = (state == IDLE) && req;
  assign start  = accept && !zero;

`ifdef INT_DIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;

  assign sa    = is_signed & a[W-1];
  assign sb    = is_signed & b[W-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;
  assign q_fix = neg_q ? -quo_n : quo_n;
  assign r_fix = neg_r ? -rem_n : rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
  assign q_fix = quo_n;
  assign r_fix = rem_n;
`endif

  // Chain of BPC restoring steps; pr stays below 2*|b| so W+1 bits suffice.
  always_comb begin
    pr    = {1'b0, rem};
    dvd_n = dvd;
    quo_n = quo;
    for (int i = 0; i < BPC; i++) begin
      pr    = {pr[W-1:0], dvd_n[W-1]};
      dvd_n = {dvd_n[W-2:0], 1'b0};
      if (pr >= {1'b0, dvs}) begin
        pr    = pr - {1'b0, dvs};
        quo_n = {quo_n[W-2:0], 1'b1};
      end else begin
        quo_n = {quo_n[W-2:0], 1'b0};
      end
    end
    rem_n = pr[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      rem         <= '0;
      ack         <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      ack <= 1'b0;
      if (accept && zero) begin
        ack         <= 1'b1;
        div_by_zero <= 1'b1;
        quotient    <= '1;
        remainder   <= a;
      end else if (start) begin
        dvd <= a_mag;
        dvs <= b_mag;
        quo <= '0;
        rem <= '0;
        cnt <= CW'(STEPS - 1);
      end
      if (state == RUN) begin
        dvd <= dvd_n;
        quo <= quo_n;
        rem <= rem_n;
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          ack         <= 1'b1;
          div_by_zero <= 1'b0;
          quotient    <= q_fix;
          remainder   <= r_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_int_div_radix.sv
// Scoreboard bench for int_div_radix at radix 2 and radix 16.
// Signed cases are exercised when INT_DIV_SIGNED_EN is defined.
module tb_int_div_radix;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, req, req4, sgn;
  logic [31:0] a, b;
  logic        busy, ack, dz, busy4, ack4, dz4;
  logic [31:0] q, r, q4, r4;

  res_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  int_div_radix #(.bitwidth(32), .bits_per_cycle(1)) u0 (
    .clk(clk), .rst(rst), .req(req),
`ifdef INT_DIV_SIGNED_EN
    .is_signed(sgn),
`endif
    .a(a), .b(b), .busy(busy), .ack(ack),
    .quotient(q), .remainder(r), .div_by_zero(dz)
  );

  int_div_radix #(.bitwidth(32), .bits_per_cycle(4)) u4 (
    .clk(clk), .rst(rst), .req(req4),
`ifdef INT_DIV_SIGNED_EN
    .is_signed(sgn),
`endif
    .a(a), .b(b), .busy(busy4), .ack(ack4),
    .quotient(q4), .remainder(r4), .div_by_zero(dz4)
  );

  function automatic res_t model(input logic [31:0] av, bv, input bit s);
    res_t e;
    if (bv == 0) begin
      e.q = '1; e.r = av; e.dz = 1'b1;
    end else if (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      e.q = av; e.r = '0; e.dz = 1'b0;
    end else if (s) begin
      e.q = $signed(av) / $signed(bv);
      e.r = $signed(av) % $signed(bv);
      e.dz = 1'b0;
    end else begin
      e.q = av / bv; e.r = av % bv; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input bit four, now,
                       input logic [31:0] av, bv, input bit s);
    if (!now) @(negedge clk);
    a = av; b = bv; sgn = s;
    if (four) req4 = 1'b1;
    else      req  = 1'b1;
    sb.push_back(model(av, bv, s));
    @(posedge clk);
    #1 req = 1'b0; req4 = 1'b0;
  endtask

  task automatic wait_ack(input bit four, output int lat, output int nb);
    bit got = 0;
    lat = 0; nb = 0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge clk);
      if (four ? ack4 : ack) begin
        lat = i; got = 1;
      end else if (four ? busy4 : busy) begin
        nb++;
      end
    end
    if (!got) $display("FAIL ack_timeout: no ack within 100 cycles");
  endtask

  function automatic res_t obs(input bit four);
    res_t o;
    o.q  = four ? q4 : q;
    o.r  = four ? r4 : r;
    o.dz = four ? dz4 : dz;
    return o;
  endfunction

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; req4 = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, ack, q, r, dz} !== '0)
      $display("FAIL reset_r2: got b%b a%b q%h r%h dz%b want all 0",
               busy, ack, q, r, dz);
    else passed++;
    checks++;
    if ({busy4, ack4, q4, r4, dz4} !== '0)
      $display("FAIL reset_r16: got b%b a%b q%h r%h dz%b want all 0",
               busy4, ack4, q4, r4, dz4);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [31:0] ta[8] = '{100, 0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'h1234_5678, 32'h8000_0000, 0};
    logic [31:0] tb[8] = '{7, 5, 9, 32'hFFFF_FFFF, 1, 10, 3, 0};
    int lat, nb;
    res_t e, o;
    ta[7] = $urandom; tb[7] = $urandom_range(1, 65535);
    for (int i = 0; i < 8; i++) begin
      issue(0, 0, ta[i], tb[i], 0);
      wait_ack(0, lat, nb);
      e = sb.pop_front(); o = obs(0);
      checks++;
      if (o !== e || lat != 33 || nb != 32)
        $display("FAIL unsigned_%0d: got q%h r%h dz%b lat%0d busy%0d want q%h r%h dz%b lat33 busy32",
                 i, o.q, o.r, o.dz, lat, nb, e.q, e.r, e.dz);
      else passed++;
    end
  endtask

  task automatic test_div0;
    int lat, nb;
    res_t e, o;
    issue(0, 0, 32'h1234, 0, 0);
    wait_ack(0, lat, nb);
    e = sb.pop_front(); o = obs(0);
    checks++;
    if (o !== e || lat != 1 || nb != 0)
      $display("FAIL div0: got q%h r%h dz%b lat%0d busy%0d want q%h r%h dz%b lat1 busy0",
               o.q, o.r, o.dz, lat, nb, e.q, e.r, e.dz);
    else passed++;
    issue(0, 0, 100, 7, 0);
    wait_ack(0, lat, nb);
    e = sb.pop_front(); o = obs(0);
    checks++;
    if (o !== e || lat != 33)
      $display("FAIL div0_clear: got q%h r%h dz%b lat%0d want q%h r%h dz%b lat33",
               o.q, o.r, o.dz, lat, e.q, e.r, e.dz);
    else passed++;
  endtask

`ifdef INT_DIV_SIGNED_EN
  task automatic test_signed;
    logic [31:0] ta[5] = '{-7, 32'h8000_0000, 7, -100, 100};
    logic [31:0] tb[5] = '{2, 32'hFFFF_FFFF, -2, -7, 0};
    int lat, nb;
    res_t e, o;
    for (int i = 0; i < 5; i++) begin
      issue(i[0], 0, ta[i], tb[i], 1);
      wait_ack(i[0], lat, nb);
      e = sb.pop_front(); o = obs(i[0]);
      checks++;
      if (o !== e)
        $display("FAIL signed_%0d: got q%h r%h dz%b want q%h r%h dz%b",
                 i, o.q, o.r, o.dz, e.q, e.r, e.dz);
      else passed++;
    end
    issue(0, 0, 100, 7, 0);
    wait_ack(0, lat, nb);
    e = sb.pop_front(); o = obs(0);
    checks++;
    if (o !== e)
      $display("FAIL signed_off: got q%h r%h want q%h r%h",
               o.q, o.r, e.q, e.r);
    else passed++;
  endtask
`endif

  task automatic test_radix16;
    logic [31:0] ta[3] = '{32'hFFFF_FFFF, 100, 0};
    logic [31:0] tb[3] = '{1, 7, 0};
    int lat, nb;
    res_t e, o;
    ta[2] = $urandom; tb[2] = $urandom_range(1, 4095);
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, ta[i], tb[i], 0);
      wait_ack(1, lat, nb);
      e = sb.pop_front(); o = obs(1);
      checks++;
      if (o !== e || lat != 9 || nb != 8)
        $display("FAIL radix16_%0d: got q%h r%h lat%0d busy%0d want q%h r%h lat9 busy8",
                 i, o.q, o.r, lat, nb, e.q, e.r);
      else passed++;
    end
  endtask

  task automatic test_ignore_req;
    int lat, nb, extra;
    res_t e, o, prev;
    prev = obs(0);
    issue(0, 0, 1000, 9, 0);
    repeat (5) @(negedge clk);
    a = 7; b = 1; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    o = obs(0);
    checks++;
    if (o !== prev)
      $display("FAIL hold_in_run: got q%h r%h want q%h r%h",
               o.q, o.r, prev.q, prev.r);
    else passed++;
    wait_ack(0, lat, nb);
    e = sb.pop_front(); o = obs(0);
    checks++;
    if (o !== e || lat != 28)
      $display("FAIL ignore_req: got q%h r%h lat%0d want q%h r%h lat28",
               o.q, o.r, lat, e.q, e.r);
    else passed++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (ack || busy) extra++;
    end
    checks++;
    if (extra != 0)
      $display("FAIL no_queued_req: got %0d active cycles want 0", extra);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    res_t e, o;
    issue(0, 0, 32'hDEAD_BEEF, 13, 0);
    wait_ack(0, lat, nb);
    e = sb.pop_front(); o = obs(0);
    checks++;
    if (o !== e)
      $display("FAIL b2b_first: got q%h r%h want q%h r%h",
               o.q, o.r, e.q, e.r);
    else passed++;
    issue(0, 1, 32'h0BAD_F00D, 77, 0);
    wait_ack(0, lat, nb);
    e = sb.pop_front(); o = obs(0);
    checks++;
    if (o !== e || lat != 33)
      $display("FAIL b2b_second: got q%h r%h lat%0d want q%h r%h lat33",
               o.q, o.r, lat, e.q, e.r);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    int acks;
    issue(0, 0, 100, 7, 0);
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ack, q, r, dz} !== '0)
      $display("FAIL rst_mid_run: got b%b a%b q%h r%h dz%b want all 0",
               busy, ack, q, r, dz);
    else passed++;
    acks = 0;
    repeat (40) begin
      @(negedge clk);
      if (ack || busy) acks++;
    end
    checks++;
    if (acks != 0)
      $display("FAIL rst_no_ack: got %0d active cycles want 0", acks);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_div0;
`ifdef INT_DIV_SIGNED_EN
    test_signed;
`endif
    test_radix16;
    test_ignore_req;
    test_back_to_back;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/int_div_radix.md
# int_div_radix

Parametrised multi-cycle integer divider. It computes quotient and remainder of two `bitwidth`-bit operands, retiring `bits_per_cycle` quotient bits per clock with restoring division. It has a single-cycle divide-by-zero fast path and supports optional signed operation with RISC-V DIV/REM semantics. It sits behind the ALU issue stage as a shared long-latency unit, using a req/ack handshake plus a busy flag for back-pressure.

## Interface
- `bitwidth`, default 32: operand/result width; must be a multiple of `bits_per_cycle`.
- `bits_per_cycle`, default 1: quotient bits resolved per RUN cycle; legal values are 1, 2, 4.
- `clk  input  1  clock; all state updates on posedge.`
- `rst  input  1  synchronous, active-high reset.`
- `req  input  1  start request; sampled only while idle.`
- `is_signed  input  1  1 = signed divide, 0 = unsigned; sampled with req (present only with INT_DIV_SIGNED_EN).`
- `a  input  bitwidth  dividend; sampled with req.`
- `b  input  bitwidth  divisor; sampled with req.`
- `busy  output  1  high while a division is in progress.`
- `ack  output  1  one-cycle pulse; results valid.`
- `quotient  output  bitwidth  result quotient; held until the next accepted req.`
- `remainder  output  bitwidth  result remainder; held until the next accepted req.`
- `div_by_zero  output  1  set with ack when b was 0; held with the results.`

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, with a step counter running from `steps-1` down to 0, where `steps = bitwidth/bits_per_cycle`.
- IDLE with `req`=1:
  - If `b`=0: stay in IDLE. Next cycle `ack`=1, `div_by_zero`=1, `quotient`=all ones, `remainder`=`a`.
  - Otherwise: latch operand magnitudes and the sign flags, clear the working quotient and partial remainder, and go to RUN.
- RUN, each cycle performs `bits_per_cycle` restoring steps, MSB first:
  - Partial remainder (width `bitwidth+1`) = {partial remainder, next dividend bit}.
  - If partial remainder >= |b|: subtract |b| and shift in quotient bit 1; otherwise shift in 0.
  - On the cycle with counter = 0: register the sign-corrected results, pulse `ack` for one cycle, clear `div_by_zero`, and go to IDLE.
- Signed sign rules:
  - Quotient is negated when sign(a) XOR sign(b).
  - Remainder takes the sign of `a`.
  - Overflow case, MIN / -1: `quotient`=MIN, `remainder`=0, with no special flag. This falls out of the magnitude path and must match the stated values.
- A `req` in RUN is ignored; it is neither queued nor allowed to corrupt operands.
- A `req` in the same cycle `ack` is high is accepted, since the state is already IDLE. This gives back-to-back throughput of one result per `steps+1` cycles.
- `ack` never stays high for more than one cycle.

## Timing
- Reset: state IDLE; `busy`, `ack`, `div_by_zero`=0; `quotient`, `remainder`=0; the step counter is cleared.
- `rst` mid-RUN abandons the operation: no `ack` is produced, and outputs return to reset values on the next cycle.
- With `req` sampled in cycle 0 and `b`≠0:
  - `busy`=1 in cycles 1..`steps`.
  - `ack`=1 in cycle `steps+1`.
  - Defaults: ack in cycle 33; with `bits_per_cycle`=4, ack in cycle 9.
- Divide by zero: `ack` in cycle 1; `busy` stays 0.
- Results change only on the `ack` edge.
- Critical path: `bits_per_cycle` chained (`bitwidth+1`)-bit compare/subtract stages.

## Configuration
- `INT_DIV_SIGNED_EN` defined:
  - The `is_signed` port exists.
  - The negation logic on operands and results is instantiated.
- `INT_DIV_SIGNED_EN` undefined:
  - The `is_signed` port is absent.
  - All operations are unsigned and the negation logic is not built.
  - Divide-by-zero behaviour is unchanged.

## Test plan
- Unsigned, defaults, `a`=100, `b`=7: `ack` in cycle 33, `quotient`=14, `remainder`=2; `busy` high in cycles 1..32.
- `b`=0, `a`=0x1234: `ack` in cycle 1, `quotient`=0xFFFFFFFF, `remainder`=0x1234, `div_by_zero`=1; the next nonzero divide clears `div_by_zero`.
- Signed (macro on): `a`=-7, `b`=2 gives `quotient`=-3, `remainder`=-1; `a`=0x80000000, `b`=-1 gives `quotient`=0x80000000, `remainder`=0.
- `bits_per_cycle`=4, `a`=0xFFFFFFFF, `b`=1: `ack` in cycle 9, `quotient`=0xFFFFFFFF, `remainder`=0.
- `req` with new operands during RUN is ignored, and the original result is unchanged. A `req` in the ack cycle starts a new divide, whose ack comes `steps+1` cycles later.
- `rst` asserted in cycle 10 of a RUN: no `ack` ever appears for that request; outputs read 0 and `busy`=0 from cycle 11.
